deserializer_fsm: RTL

Serial-to-parallel stage downstream of the FIR datapath serializer. Collects an LSB-first bit stream under a valid/ready handshake and assembles LENGTH-bit words. Presents each word on a parallel valid/ready output port. A shift register plus an output holding register let the next word be collected while the current word waits for the consumer; backpressure reaches the serial side only when both registers are full.

---
 rtl/fir_serdes_pkg.sv | 19 +
 rtl/deserializer_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fir_serdes_pkg.sv
// -----------------------------------------------------------------------------
// fir_serdes_pkg
// Shared definitions for the FIR serializer / deserializer pair.
//   - fir_serdes_state_e : FSM state codes EMPTY / HOLD / FULL. The codes are
//                          one-hot compatible so they look the same as the
//                          serializer's state codes in waveforms.
//   - FIR_WORD_LENGTH    : default parallel word width.
// -----------------------------------------------------------------------------
package fir_serdes_pkg;

  localparam int FIR_WORD_LENGTH = 32;

  typedef enum logic [2:0] {
    EMPTY = 3'b001,  // no word pending on the parallel side
    HOLD  = 3'b010,  // out_reg holds a word and collection continues
    FULL  = 3'b100   // out_reg holds a word and shift_reg holds the next one
  } fir_serdes_state_e;

endpackage : fir_serdes_pkg

// File: rtl/deserializer_fsm.sv
// -----------------------------------------------------------------------------
// deserializer_fsm
// Collects an LSB-first serial bit stream and presents LENGTH-bit words on a
// parallel port. The shift register collects the next word while the output
// holding register (out_reg) waits for the consumer. Serial backpressure is
// applied only when both registers hold complete words.
//
// Ports
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_en         : clock enable; when low all state and outputs hold
//   i_din        : serial data bit (first bit of a word is its LSB)
//   i_din_valid  : i_din carries a bit this cycle
//   o_ready      : registered; a serial bit is accepted this cycle if valid
//   ov_dout      : assembled word (output holding register)
//   o_dout_valid : registered; ov_dout holds a complete word
//   i_ready      : consumer accepts ov_dout this cycle
//   o_dbg_state  : current FSM state code (debug visibility only)
//
// Handshake: both ports use valid/ready. A transfer happens on a rising edge
// where i_en, valid and ready are all high. A producer that has raised valid
// keeps valid and data stable until that transfer. The enable gates both
// ports, so with i_en low nothing transfers.
// -----------------------------------------------------------------------------
module deserializer_fsm
  import fir_serdes_pkg::*;
#(
  parameter int LENGTH = FIR_WORD_LENGTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic [2:0]        o_dbg_state
);

  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(LENGTH - 1);

  fir_serdes_state_e state_q, state_d;
  logic [LENGTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LENGTH-1:0] out_reg_q, out_reg_d;
  logic              ready_q, ready_d;
  logic              dout_valid_q, dout_valid_d;

  logic              bit_acc;
  logic              word_done;
  logic              word_take;
  logic [LENGTH-1:0] assembled;

  // Handshake events. Both are qualified by the enable, so a frozen block
  // neither accepts a bit nor gives up a word.
  assign bit_acc   = i_en & i_din_valid & ready_q;
  assign word_done = bit_acc & (bit_cnt_q == LAST_BIT);
  assign word_take = i_en & dout_valid_q & i_ready;
  // LSB-first: new bits enter at the top and shift down, so after LENGTH bits
  // the first bit received is in bit 0.
  assign assembled = {i_din, shift_reg_q[LENGTH-1:1]};

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= EMPTY;
      shift_reg_q  <= '0;
      bit_cnt_q    <= '0;
      out_reg_q    <= '0;
      ready_q      <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      bit_cnt_q    <= bit_cnt_d;
      out_reg_q    <= out_reg_d;
      ready_q      <= ready_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (word_done) state_d = HOLD;
      end
      HOLD: begin
        // done & take keeps HOLD: the new word replaces the one just taken.
        if (word_done && !word_take)      state_d = FULL;
        else if (!word_done && word_take) state_d = EMPTY;
      end
      FULL: begin
        // o_ready is low in FULL, so no bit can complete here.
        if (word_take) state_d = HOLD;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_reg_d  = shift_reg_q;
    bit_cnt_d    = bit_cnt_q;
    out_reg_d    = out_reg_q;
    ready_d      = ready_q;
    dout_valid_d = dout_valid_q;

    if (bit_acc) begin
      shift_reg_d = assembled;
      bit_cnt_d   = word_done ? '0 : bit_cnt_q + 1'b1;
    end

    unique case (state_q)
      EMPTY: begin
        if (word_done) out_reg_d = assembled;
      end
      HOLD: begin
        if (word_done && word_take) out_reg_d = assembled;
      end
      FULL: begin
        // The word parked in shift_reg moves to the output register.
        if (word_take) out_reg_d = shift_reg_q;
      end
      default: ;
    endcase

    // The flags are registered versions of the next state. This makes o_ready
    // rise on the first enabled edge after reset.
    if (i_en) begin
      ready_d      = (state_d != FULL);
      dout_valid_d = (state_d != EMPTY);
    end
  end

  assign o_ready      = ready_q;
  assign o_dout_valid = dout_valid_q;
  assign ov_dout      = out_reg_q;
  assign o_dbg_state  = state_q;

endmodule : deserializer_fsm
